mesi_bus_responder: RTL

Shared-bus side of the MESI snooping protocol: collects bus requests (read miss, write miss, invalidate) and write-back flags from NCACHE cache controllers, arbitrates round-robin, broadcasts each granted request to every other cache's snoop input, gathers shared/write-back responses, models memory latency and signals completion to the requester. Sits between the per-cache MESI controllers and the memory model.

---
 rtl/mesi_pkg.sv | 31 +++
 rtl/mesi_rr_arbiter.sv | 31 +++
 rtl/mesi_bus_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mesi_pkg.sv
// Shared definitions for the MESI snooping-bus responder: bus/memory command
// codes, cache line state encodings and the responder state enum.
package mesi_pkg;

  localparam logic [1:0] BUS_NONE    = 2'b00;
  localparam logic [1:0] BUS_RD_MISS = 2'b01;
  localparam logic [1:0] BUS_WR_MISS = 2'b10;
  localparam logic [1:0] BUS_INVAL   = 2'b11;

  localparam logic [1:0] MEM_NONE       = 2'b00;
  localparam logic [1:0] MEM_WRITE_BACK = 2'b10;

  localparam logic [1:0] CST_I = 2'b00;
  localparam logic [1:0] CST_S = 2'b01;
  localparam logic [1:0] CST_E = 2'b10;
  localparam logic [1:0] CST_M = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_RESP,
    ST_WB,
    ST_MEM,
    ST_DONE
  } resp_state_e;

  function automatic logic is_miss(input logic [1:0] cmd);
    return (cmd == BUS_RD_MISS) || (cmd == BUS_WR_MISS);
  endfunction

endpackage

// File: rtl/mesi_rr_arbiter.sv
// Combinational round-robin arbiter: searches pending starting at the index
// after the last grant and returns a one-hot grant (zero when nothing pending).
module mesi_rr_arbiter #(
  parameter int NCACHE = 4,
  parameter int LW     = 2
) (
  input  logic [NCACHE-1:0] pending,
  input  logic [LW-1:0]     last,
  output logic [NCACHE-1:0] grant
);

  int  pos;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NCACHE; k++) begin
      pos = int'(last) + k;
      if (pos >= NCACHE) pos = pos - NCACHE;
      for (int i = 0; i < NCACHE; i++) begin
        if (!found && pos == i && pending[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mesi_bus_responder.sv
// Shared-bus responder for MESI snooping caches: capture, round-robin grant,
// snoop broadcast, write-back/memory latency and completion.
// Option MESI_BUS_ABORT_EN: a miss that triggers a write-back skips the memory read.
//
// state    | meaning
// IDLE     | waiting for a pending request
// SNOOP    | broadcasting granted command, sampling shared hits
// RESP     | sampling write-back responses, choosing next phase
// WB       | memory write-back for MEM_LAT cycles
// MEM      | memory read for MEM_LAT cycles
// DONE     | completion pulse to the requester
module mesi_bus_responder
  import mesi_pkg::*;
#(
  parameter int NCACHE  = 4,
  parameter int MEM_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NCACHE-1:0]   req_bus,
  input  logic [2*NCACHE-1:0]   req_mem,
  input  logic [NCACHE-1:0]     shared_hit,
  output logic [2*NCACHE-1:0]   snoop_bus,
  output logic [NCACHE-1:0]     grant,
  output logic [NCACHE-1:0]     done,
  output logic                  shared_rsp,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  busy
);

  localparam int              LW       = $clog2(NCACHE);
  localparam logic [LW-1:0]   LAST_RST = LW'(NCACHE - 1);
  localparam logic [3:0]      LAT_LOAD = 4'(MEM_LAT - 1);

  resp_state_e           state;
  logic [2*NCACHE-1:0]   prev_bus;
  logic [2*NCACHE-1:0]   cmd_q;
  logic [NCACHE-1:0]     pending;
  logic [NCACHE-1:0]     capture;
  logic [NCACHE-1:0]     arb_grant;
  logic [NCACHE-1:0]     grant_clr;
  logic [LW-1:0]         last_q;
  logic [LW-1:0]         arb_idx;
  logic [1:0]            arb_cmd;
  logic [1:0]            cmd_g;
  logic                  shared_q;
  logic                  wb_now;
  logic [3:0]            cnt;

  mesi_rr_arbiter #(.NCACHE(NCACHE), .LW(LW)) u_arb (
    .pending (pending),
    .last    (last_q),
    .grant   (arb_grant)
  );

  // The granted cache is masked from capture until its DONE cycle has ended.
  always_comb begin
    capture   = '0;
    wb_now    = 1'b0;
    arb_idx   = '0;
    arb_cmd   = BUS_NONE;
    grant_clr = (state == ST_IDLE) ? arb_grant : '0;
    for (int i = 0; i < NCACHE; i++) begin
      capture[i] = (req_bus[2*i +: 2] != prev_bus[2*i +: 2]) &&
                   (req_bus[2*i +: 2] != BUS_NONE) && !grant[i];
      if (!grant[i] && req_mem[2*i +: 2] == MEM_WRITE_BACK) wb_now = 1'b1;
      if (arb_grant[i]) begin
        arb_idx = LW'(i);
        arb_cmd = cmd_q[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bus <= '0;
      cmd_q    <= '0;
      pending  <= '0;
    end else begin
      prev_bus <= req_bus;
      pending  <= (pending & ~grant_clr) | capture;
      for (int i = 0; i < NCACHE; i++) begin
        if (capture[i]) cmd_q[2*i +: 2] <= req_bus[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      done       <= '0;
      snoop_bus  <= '0;
      shared_rsp <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      last_q     <= LAST_RST;
      cmd_g      <= BUS_NONE;
      shared_q   <= 1'b0;
      cnt        <= '0;
    end else begin
      done       <= '0;
      shared_rsp <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            grant    <= arb_grant;
            last_q   <= arb_idx;
            cmd_g    <= arb_cmd;
            shared_q <= 1'b0;
            busy     <= 1'b1;
            for (int j = 0; j < NCACHE; j++) begin
              snoop_bus[2*j +: 2] <= arb_grant[j] ? BUS_NONE : arb_cmd;
            end
            state <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          snoop_bus <= '0;
          shared_q  <= |(shared_hit & ~grant);
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (wb_now) begin
            mem_wr <= 1'b1;
            cnt    <= LAT_LOAD;
            state  <= ST_WB;
          end else if (is_miss(cmd_g)) begin
            mem_rd <= 1'b1;
            cnt    <= LAT_LOAD;
            state  <= ST_MEM;
          end else begin
            done       <= grant;
            shared_rsp <= shared_q && (cmd_g == BUS_RD_MISS);
            state      <= ST_DONE;
          end
        end
        ST_WB: begin
          if (cnt == 4'd0) begin
            mem_wr <= 1'b0;
`ifdef MESI_BUS_ABORT_EN
            // Write-back data satisfies the requester; memory read is skipped.
            done       <= grant;
            shared_rsp <= shared_q && (cmd_g == BUS_RD_MISS);
            state      <= ST_DONE;
`else
            if (is_miss(cmd_g)) begin
              mem_rd <= 1'b1;
              cnt    <= LAT_LOAD;
              state  <= ST_MEM;
            end else begin
              done       <= grant;
              shared_rsp <= 1'b0;
              state      <= ST_DONE;
            end
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_MEM: begin
          if (cnt == 4'd0) begin
            mem_rd     <= 1'b0;
            done       <= grant;
            shared_rsp <= shared_q && (cmd_g == BUS_RD_MISS);
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
